// File: rtl/fir_pkg.sv
// ============================================================================
// fir_pkg
// Shared definitions for the folded FIR filterbank datapath stages.
//   - Default widths of the multiplier product, the accumulator and the output.
//   - Frame length (products per output sample) and fraction shift.
//   - State encoding of the product accumulator FSM.
// ============================================================================
package fir_pkg;

    // Signed product width delivered by the shared multiplier (16b x 11b).
    localparam int PROD_WIDTH = 27;
    // Products summed into one output sample.
    localparam int NUM_TAPS   = 8;
    // Accumulator width; holds NUM_TAPS full-scale products without wrapping.
    localparam int ACC_WIDTH  = 32;
    // Coefficient fraction bits removed from the sum.
    localparam int FRAC_SHIFT = 11;
    // Signed output sample width.
    localparam int OUT_WIDTH  = 16;

    // Accumulator FSM: collecting products, or holding a finished sample.
    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } fir_state_t;

endpackage : fir_pkg

// File: rtl/fir_round_sat.sv
// ============================================================================
// fir_round_sat
// Combinational round-half-up, arithmetic right shift and saturation of a
// signed accumulator value down to a signed output sample.
//   sum    : in  ACC_WIDTH  signed accumulated value
//   result : out OUT_WIDTH  signed rounded, shifted, clamped sample
//   sat    : out 1          clamping was applied to this sample
// Parameter constraints: FRAC_SHIFT >= 1, OUT_WIDTH <= ACC_WIDTH + 1.
// ============================================================================
module fir_round_sat #(
    parameter int ACC_WIDTH  = fir_pkg::ACC_WIDTH,
    parameter int FRAC_SHIFT = fir_pkg::FRAC_SHIFT,
    parameter int OUT_WIDTH  = fir_pkg::OUT_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0] sum,
    output logic signed [OUT_WIDTH-1:0] result,
    output logic                        sat
);
    import fir_pkg::*;

    // One extra bit so that adding the rounding constant can never wrap.
    localparam int EXT_W = ACC_WIDTH + 1;

    localparam logic signed [EXT_W-1:0] HALF_LSB = EXT_W'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [EXT_W-1:0] OUT_MAX  = (EXT_W'(1) << (OUT_WIDTH - 1)) - EXT_W'(1);
    // Bitwise inverse of the positive limit is the most negative output value.
    localparam logic signed [EXT_W-1:0] OUT_MIN  = ~OUT_MAX;

    logic signed [EXT_W-1:0] sum_ext_s;
    logic signed [EXT_W-1:0] rounded_s;
    logic signed [EXT_W-1:0] shifted_s;

    assign sum_ext_s = {sum[ACC_WIDTH-1], sum};
    assign rounded_s = sum_ext_s + HALF_LSB;
    // Arithmetic shift floors, so adding half an LSB first gives ties toward +inf.
    assign shifted_s = rounded_s >>> FRAC_SHIFT;

    // Clamp the shifted value into the signed output range.
    always_comb begin
        result = shifted_s[OUT_WIDTH-1:0];
        sat    = 1'b0;
        if (shifted_s > OUT_MAX) begin
            result = OUT_MAX[OUT_WIDTH-1:0];
            sat    = 1'b1;
        end else if (shifted_s < OUT_MIN) begin
            result = OUT_MIN[OUT_WIDTH-1:0];
            sat    = 1'b1;
        end else begin
            result = shifted_s[OUT_WIDTH-1:0];
            sat    = 1'b0;
        end
    end

endmodule : fir_round_sat

// File: rtl/fir_product_accumulator.sv
// ============================================================================
// fir_product_accumulator
// Sums NUM_TAPS consecutive signed products from the folded FIR multiplier
// into one output sample, then rounds, shifts and saturates it to OUT_WIDTH.
// The finished sample is held on a valid/ready port until accepted.
//   ap_clk     : in  1           clock, rising edge
//   ap_rst     : in  1           asynchronous active-high reset
//   prod_data  : in  PROD_WIDTH  signed product
//   prod_valid : in  1           prod_data is valid
//   prod_ready : out 1           product accepted this cycle (state decode)
//   out_data   : out OUT_WIDTH   signed rounded/saturated sum (registered)
//   out_valid  : out 1           out_data is valid (registered)
//   out_ready  : in  1           consumer accepts out_data
//   sat_flag   : out 1           sticky: some output saturated since reset
// Parameter constraints: NUM_TAPS >= 2,
//   ACC_WIDTH >= PROD_WIDTH + clog2(NUM_TAPS), FRAC_SHIFT >= 1.
// ============================================================================
module fir_product_accumulator #(
    parameter int PROD_WIDTH = fir_pkg::PROD_WIDTH,
    parameter int NUM_TAPS   = fir_pkg::NUM_TAPS,
    parameter int ACC_WIDTH  = fir_pkg::ACC_WIDTH,
    parameter int FRAC_SHIFT = fir_pkg::FRAC_SHIFT,
    parameter int OUT_WIDTH  = fir_pkg::OUT_WIDTH
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic signed [PROD_WIDTH-1:0] prod_data,
    input  logic                         prod_valid,
    output logic                         prod_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         sat_flag
);
    import fir_pkg::*;

    localparam int                CNT_W    = $clog2(NUM_TAPS);
    localparam logic [CNT_W-1:0]  LAST_TAP = CNT_W'(NUM_TAPS - 1);

    fir_state_t                   state_r;
    fir_state_t                   state_nxt_s;
    logic        [CNT_W-1:0]      tap_cnt_r;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic signed [ACC_WIDTH-1:0]  prod_ext_s;
    logic signed [ACC_WIDTH-1:0]  sum_s;
    logic                         accept_s;
    logic                         last_tap_s;
    logic signed [OUT_WIDTH-1:0]  rs_result_s;
    logic                         rs_sat_s;

    assign prod_ext_s = {{(ACC_WIDTH - PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    assign sum_s      = acc_r + prod_ext_s;
    assign accept_s   = prod_valid && (state_r == ST_ACCUM);
    assign last_tap_s = (tap_cnt_r == LAST_TAP);

    fir_round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_round_sat (
        .sum    (sum_s),
        .result (rs_result_s),
        .sat    (rs_sat_s)
    );

    // FSM state register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r <= ST_ACCUM;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and the prod_ready decode of the current state.
    always_comb begin
        state_nxt_s = state_r;
        prod_ready  = 1'b0;
        case (state_r)
            ST_ACCUM: begin
                prod_ready = 1'b1;
                if (prod_valid && last_tap_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                prod_ready = 1'b0;
                if (out_ready) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                prod_ready  = 1'b0;
                state_nxt_s = ST_ACCUM;
            end
        endcase
    end

    // Accumulator, tap counter, output register and sticky saturation flag.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc_r     <= '0;
            tap_cnt_r <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (accept_s) begin
            if (last_tap_s) begin
                // Closing product of the frame: publish and restart the sum.
                acc_r     <= '0;
                tap_cnt_r <= '0;
                out_data  <= rs_result_s;
                out_valid <= 1'b1;
                sat_flag  <= sat_flag | rs_sat_s;
            end else begin
                acc_r     <= sum_s;
                tap_cnt_r <= tap_cnt_r + CNT_W'(1);
            end
        end else if ((state_r == ST_HOLD) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : fir_product_accumulator

// File: tb/tb_fir_product_accumulator.sv
// ============================================================================
// tb_fir_product_accumulator
// Directed scoreboard bench: each frame pushes its hand-computed result into a
// queue, and a monitor pops and compares on every output handshake.
// ============================================================================
module tb_fir_product_accumulator;

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic signed [26:0] prod_data;
    logic               prod_valid;
    logic               prod_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               sat_flag;

    int errors        = 0;
    int checks        = 0;
    int outs_seen     = 0;
    int outs_expected = 0;

    logic signed [15:0] exp_data_q [$];
    logic               exp_sat_q  [$];

    fir_product_accumulator dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .prod_data  (prod_data),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sat_flag   (sat_flag)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input logic s);
        exp_data_q.push_back(d[15:0]);
        exp_sat_q.push_back(s);
        outs_expected++;
    endtask

    // Present one product from a falling edge; return on the falling edge
    // after the rising edge that accepted it.
    task automatic send_prod(input int v);
        int   n = 0;
        logic ok;
        prod_data  = v[26:0];
        prod_valid = 1'b1;
        forever begin
            ok = prod_ready;
            @(posedge ap_clk);
            @(negedge ap_clk);
            if (ok) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: product %0d not accepted in 100 cycles", v);
                break;
            end
        end
    endtask

    task automatic send_const(input int v, input int n, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            if (bubbles && ($urandom_range(0, 1) == 1)) begin
                prod_valid = 1'b0;
                prod_data  = 27'sd12345;
                repeat ($urandom_range(1, 3)) @(negedge ap_clk);
            end
            send_prod(v);
        end
        prod_valid = 1'b0;
    endtask

    // Scoreboard monitor: compare on every completed output handshake.
    initial begin : monitor
        logic signed [15:0] d;
        logic               s;
        forever begin
            @(negedge ap_clk);
            #1;
            if (!ap_rst && out_valid && out_ready) begin
                outs_seen++;
                if (exp_data_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d, expected no output", out_data);
                end else begin
                    d = exp_data_q.pop_front();
                    s = exp_sat_q.pop_front();
                    chk("out_data", out_data, d);
                    chk("sat_flag", sat_flag, s);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int low;
        ap_rst     = 1'b1;
        prod_valid = 1'b0;
        prod_data  = '0;
        out_ready  = 1'b1;
        repeat (2) @(negedge ap_clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_prod_ready", prod_ready, 1);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        // Basic frame: 8 x 2048 -> (16384 + 1024) >> 11 = 8.
        push_exp(8, 1'b0);
        send_const(2048, 8, 1'b0);
        chk("s1_latency_valid", out_valid, 1);
        low = 0;
        for (int i = 0; i < 4; i++) begin
            if (!prod_ready) low++;
            @(negedge ap_clk);
        end
        chk("s1_ready_low_cycles", low, 1);

        // Rounding ties: 3072 -> 2, -3072 -> -1.
        push_exp(2, 1'b0);
        send_prod(3072);
        send_const(0, 7, 1'b0);
        push_exp(-1, 1'b0);
        send_prod(-3072);
        send_const(0, 7, 1'b0);
        repeat (2) @(negedge ap_clk);
        chk("s2_sat_clear", sat_flag, 0);

        // Backpressure: hold 5 cycles while products are offered.
        out_ready = 1'b0;
        push_exp(8, 1'b0);
        send_const(2048, 8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            prod_valid = 1'b1;
            prod_data  = 27'sd999;
            chk("s4_hold_valid", out_valid, 1);
            chk("s4_hold_data", out_data, 8);
            chk("s4_hold_ready", prod_ready, 0);
            @(negedge ap_clk);
        end
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge ap_clk);
        // 8 x -2048: (-16384 + 1024) >> 11 = floor(-7.5) = -8.
        push_exp(-8, 1'b0);
        send_const(-2048, 8, 1'b0);

        // Bubbles: 8 x 100 -> (800 + 1024) >> 11 = 0.
        push_exp(0, 1'b0);
        send_const(100, 8, 1'b1);

        // Saturation both ways; flag is sticky.
        push_exp(32767, 1'b1);
        send_const(67108863, 8, 1'b0);
        push_exp(-32768, 1'b1);
        send_const(-67108864, 8, 1'b0);
        repeat (2) @(negedge ap_clk);
        chk("s3_sat_sticky", sat_flag, 1);

        // Reset while holding a sample: output dropped before the next edge.
        out_ready = 1'b0;
        send_const(2048, 8, 1'b0);
        chk("s6_hold_valid", out_valid, 1);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("s6_async_valid", out_valid, 0);
        chk("s6_async_data", out_data, 0);
        chk("s6_async_sat", sat_flag, 0);
        chk("s6_async_ready", prod_ready, 1);
        @(negedge ap_clk);
        ap_rst    = 1'b0;
        out_ready = 1'b1;
        @(negedge ap_clk);

        // Mid-frame reset after 3 products; the partial sum is discarded.
        send_const(2048, 3, 1'b0);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("s6_mid_valid", out_valid, 0);
        chk("s6_mid_ready", prod_ready, 1);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        push_exp(8, 1'b0);
        send_const(2048, 8, 1'b0);
        chk("s6_frame_latency", out_valid, 1);

        repeat (5) @(negedge ap_clk);
        chk("sb_drained", exp_data_q.size(), 0);
        chk("output_count", outs_seen, outs_expected);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fir_product_accumulator
